fifo_wr_arbiter: RTL and testbench

- Round-robin burst arbiter on the write side of the team's asynchronous count FIFO.
- Shares the single FIFO write port between NUM_REQ producers, each using a valid/ready handshake.
- Grants one requester at a time for a burst of up to MAX_BURST words and honours FIFO full backpressure.
- Lives entirely in the FIFO write clock domain; drives the FIFO wr_data/wr_en inputs.

---
 rtl/fifo_wr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin burst arbiter in front of the write port of the asynchronous
// count FIFO. NUM_REQ producers offer words with a valid/ready handshake. One
// producer at a time owns the FIFO write port for a burst of up to MAX_BURST
// words. FIFO full backpressure stalls the burst without releasing it.
// Everything runs in the FIFO write clock domain.
//
// Parameters:
//   NUM_REQ     number of requesters (1..8)
//   DATA_WIDTH  word width, equal to the FIFO DATA_WIDTH
//   MAX_BURST   maximum words per grant (1..256)
//
// Ports:
//   wr_clk            in   write-domain clock
//   wr_rst_n          in   asynchronous active-low reset
//   req_data          in   packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid         in   per-requester word available
//   req_ready         out  per-requester word accepted when valid & ready
//   fifo_full         in   FIFO full flag
//   fifo_almost_full  in   FIFO almost_full flag (optional feature only)
//   fifo_wr_data      out  FIFO write data
//   fifo_wr_en        out  FIFO write enable
//   grant             out  one-hot current owner, 0 when idle
//   word_count        out  words written since reset (wraps at 2^32)
//
// Optional feature macro: FIFO_WR_ARB_ALMOST_FULL_EN
//   Defined: no new grant is issued while fifo_almost_full=1; a burst in
//   progress is limited only by fifo_full. Undefined: fifo_almost_full is
//   ignored.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          fifo_wr_en,
    output logic [NUM_REQ-1:0]            grant,
    output logic [31:0]                   word_count
);

    // Beat counter only has to hold 0..MAX_BURST-1: the write that would
    // reach MAX_BURST releases the grant instead of incrementing.
    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_reg;
    logic [NUM_REQ-1:0]  grant_reg;
    // Last-grant pointer kept one-hot; resets to the top requester so that
    // requester 0 has first priority.
    logic [NUM_REQ-1:0]  last_grant_reg;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic [31:0]         word_count_reg;

    // ------------------------------------------------------------------
    // Round-robin pick: prefer valid requesters strictly above the last
    // owner; if none, wrap to the lowest valid one. The lowest set bit of
    // the candidate vector is isolated with v & (-v).
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_valid;
    logic [NUM_REQ-1:0] cand_valid;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               issue_ok;
    logic               owner_valid;

    assign upper_mask  = ~(last_grant_reg | (last_grant_reg - NUM_REQ'(1)));
    assign upper_valid = req_valid & upper_mask;
    assign cand_valid  = (|upper_valid) ? upper_valid : req_valid;
    assign pick_onehot = cand_valid & (~cand_valid + NUM_REQ'(1));

`ifdef FIFO_WR_ARB_ALMOST_FULL_EN
    assign issue_ok = (|req_valid) & ~fifo_full & ~fifo_almost_full;
`else
    assign issue_ok = (|req_valid) & ~fifo_full;
    logic unused_almost_full;
    assign unused_almost_full = fifo_almost_full;
`endif

    // ------------------------------------------------------------------
    // Owner-side handshake. grant_reg is zero in IDLE, so these all
    // collapse to zero there without referring to the state.
    // ------------------------------------------------------------------
    assign owner_valid = |(req_valid & grant_reg);
    assign req_ready   = fifo_full ? '0 : grant_reg;
    assign fifo_wr_en  = owner_valid & ~fifo_full;
    assign grant       = grant_reg;
    assign word_count  = word_count_reg;

    // AND-OR data mux on the one-hot grant: a column of masked bits per
    // data bit, then an OR across requesters. Output is 0 when grant=0.
    logic [DATA_WIDTH-1:0][NUM_REQ-1:0] col_bits;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            for (genvar bi = 0; bi < DATA_WIDTH; bi++) begin : g_bit
                assign col_bits[bi][gi] = grant_reg[gi] & req_data[gi*DATA_WIDTH + bi];
            end
        end
        for (genvar bi = 0; bi < DATA_WIDTH; bi++) begin : g_or
            assign fifo_wr_data[bi] = |col_bits[bi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= NUM_REQ'(1) << (NUM_REQ - 1);
            beat_cnt_reg   <= '0;
            word_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue_ok) begin
                        grant_reg    <= pick_onehot;
                        beat_cnt_reg <= '0;
                        state_reg    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_valid) begin
                        // Owner withdrew (also while full): release, no word.
                        state_reg      <= IDLE;
                        last_grant_reg <= grant_reg;
                        grant_reg      <= '0;
                    end else if (fifo_wr_en) begin
                        word_count_reg <= word_count_reg + 32'd1;
                        if (beat_cnt_reg == LAST_BEAT) begin
                            state_reg      <= IDLE;
                            last_grant_reg <= grant_reg;
                            grant_reg      <= '0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                        end
                    end
                    // Full with owner still valid: hold grant, freeze beats.
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=16,
// MAX_BURST=4). A behavioural model (owner index, beat count, last owner,
// word total) is stepped on every rising edge; one compare process checks all
// DUT outputs against it on every falling edge. Directed scenarios add
// hand-computed literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic              wr_clk = 1'b0;
    logic              wr_rst_n;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_almost_full;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_wr_en;
    logic [N-1:0]      grant;
    logic [31:0]       word_count;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .wr_clk           (wr_clk),
        .wr_rst_n         (wr_rst_n),
        .req_data         (req_data),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_en       (fifo_wr_en),
        .grant            (grant),
        .word_count       (word_count)
    );

    always #5 wr_clk = ~wr_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    // ---------------- behavioural model ----------------
    int          m_owner = -1;   // -1 = idle
    int          m_beats = 0;
    int          m_last  = N - 1;
    logic [31:0] m_count = 0;

    function automatic void model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = N - 1;
        m_count = 0;
    endfunction

    function automatic void model_step();
        bit allow;
        bit found;
        int c;
        if (!wr_rst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            allow = (req_valid != 0) && !fifo_full;
`ifdef FIFO_WR_ARB_ALMOST_FULL_EN
            allow = allow && !fifo_almost_full;
`endif
            found = 1'b0;
            if (allow) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && req_valid[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_beats = 0;
                    end
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (!fifo_full) begin
            m_count = m_count + 1;
            m_beats = m_beats + 1;
            if (m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_grant();
        return (m_owner < 0) ? '0 : (N'(1) << m_owner);
    endfunction

    function automatic logic [N-1:0] exp_ready();
        return (m_owner >= 0 && !fifo_full) ? exp_grant() : '0;
    endfunction

    function automatic logic exp_wr_en();
        return (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (m_owner < 0) ? '0 : req_data[m_owner*DW +: DW];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge wr_clk) begin
        if (check_en) begin
            chk("grant",        64'(grant),        64'(exp_grant()));
            chk("req_ready",    64'(req_ready),    64'(exp_ready()));
            chk("fifo_wr_en",   64'(fifo_wr_en),   64'(exp_wr_en()));
            chk("fifo_wr_data", 64'(fifo_wr_data), 64'(exp_data()));
            chk("word_count",   64'(word_count),   64'(m_count));
            if (fifo_wr_en)
                $display("write t=%0t grant=%b data=%h word_count=%0d",
                         $time, grant, fifo_wr_data, word_count);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge wr_clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        @(negedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        wr_rst_n = 1'b1;
    endtask

    int         exp_wcyc [10] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
    logic [3:0] exp_gseq [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int         wcyc [10];
        logic [3:0] gseq [5];
        int         gstart [5];
        int         acc, nw, ng, post;
        bit         hs, rel, found, hit;
        logic [3:0] prev;
        logic [31:0] rel_wc;

        req_valid        = '0;
        req_data         = '0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        wr_rst_n         = 1'b0;
        model_reset();
        check_en = 1'b1;
        tick();
        tick();

        // Reset values
        settle();
        chk("rst_grant",      64'(grant),        64'(0));
        chk("rst_ready",      64'(req_ready),    64'(0));
        chk("rst_wr_en",      64'(fifo_wr_en),   64'(0));
        chk("rst_wr_data",    64'(fifo_wr_data), 64'(0));
        chk("rst_word_count", 64'(word_count),   64'(0));
        tick();
        wr_rst_n = 1'b1;

        // 1) Single requester, data 0xA000.. in order
        for (int i = 0; i < 10; i++) wcyc[i] = -1;
        req_data[15:0] = 16'hA000;
        req_valid      = 4'b0001;
        acc = 0;
        nw  = 0;
        for (int cyc = 0; cyc < 40 && acc < 10; cyc++) begin
            settle();
            hs = fifo_wr_en;
            if (fifo_wr_en) begin
                if (nw < 10) begin
                    wcyc[nw] = cyc;
                    chk("t1_data", 64'(fifo_wr_data), 64'(32'hA000 + 32'(nw)));
                end
                nw++;
            end
            tick();
            if (hs) acc++;
            req_data[15:0] = 16'hA000 + 16'(acc);
        end
        settle();
        chk("t1_word_count", 64'(word_count), 64'(10));
        for (int i = 0; i < 10; i++)
            chk("t1_write_cycle", 64'(wcyc[i]), 64'(exp_wcyc[i]));
        tick();
        req_valid = '0;

        // 2) Round robin, all requesters valid
        do_reset();
        req_valid = 4'hF;
        prev = '0;
        ng   = 0;
        for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
            req_data = {$urandom, $urandom};
            settle();
            if (grant != 0 && prev == 0) begin
                gseq[ng]   = grant;
                gstart[ng] = cyc;
                ng++;
            end
            prev = grant;
            tick();
        end
        chk("t2_grants_seen", 64'(ng), 64'(5));
        for (int i = 0; i < 5; i++)
            if (i < ng) chk("t2_grant_seq", 64'(gseq[i]), 64'(exp_gseq[i]));
        for (int i = 1; i < 5; i++)
            if (i < ng) chk("t2_grant_spacing", 64'(gstart[i] - gstart[i-1]), 64'(5));
        req_valid = '0;

        // 3) Full stall for 3 cycles after 2nd word
        do_reset();
        req_data  = {$urandom, $urandom};
        req_valid = 4'b0001;
        nw = 0;
        for (int cyc = 0; cyc < 20 && nw < 2; cyc++) begin
            settle();
            if (fifo_wr_en) nw++;
            tick();
        end
        chk("t3_pre_words", 64'(nw), 64'(2));
        fifo_full = 1'b1;
        repeat (3) begin
            settle();
            chk("t3_stall_wr_en", 64'(fifo_wr_en), 64'(0));
            chk("t3_stall_ready", 64'(req_ready),  64'(0));
            chk("t3_stall_grant", 64'(grant),      64'(4'b0001));
            tick();
        end
        fifo_full = 1'b0;
        post   = 0;
        rel    = 1'b0;
        rel_wc = '0;
        for (int cyc = 0; cyc < 20 && !rel; cyc++) begin
            settle();
            if (grant == 0) begin
                rel    = 1'b1;
                rel_wc = word_count;
            end else if (fifo_wr_en) begin
                post++;
            end
            tick();
        end
        chk("t3_released",   64'(rel),    64'(1));
        chk("t3_post_words", 64'(post),   64'(2));
        chk("t3_word_count", 64'(rel_wc), 64'(4));
        req_valid = '0;

        // 4) Early release of requester 2, then requester 3, then wrap to 0
        do_reset();
        req_valid = 4'b0100;
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            settle();
            if (grant != 0) begin
                found = 1'b1;
                chk("t4_first_grant", 64'(grant),      64'(4'b0100));
                chk("t4_first_wr",    64'(fifo_wr_en), 64'(1));
            end
            tick();
        end
        chk("t4_granted", 64'(found), 64'(1));
        req_valid = 4'b1001;
        settle();
        chk("t4_drop_grant_held", 64'(grant),      64'(4'b0100));
        chk("t4_drop_no_wr",      64'(fifo_wr_en), 64'(0));
        tick();
        settle();
        chk("t4_idle", 64'(grant), 64'(0));
        tick();
        settle();
        chk("t4_next_grant", 64'(grant), 64'(4'b1000));
        tick();
        req_valid = 4'b0001;
        settle();
        chk("t4_r3_drop_held", 64'(grant), 64'(4'b1000));
        tick();
        settle();
        chk("t4_idle2", 64'(grant), 64'(0));
        tick();
        settle();
        chk("t4_wrap_grant", 64'(grant), 64'(4'b0001));
        tick();
        req_valid = '0;

        // 5) Reset during the 3rd word
        do_reset();
        req_valid = 4'hF;
        req_data  = {$urandom, $urandom};
        nw  = 0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            settle();
            if (fifo_wr_en) nw++;
            if (fifo_wr_en && nw == 3) begin
                hit = 1'b1;
                #1;
                wr_rst_n = 1'b0;
                model_reset();
                #1;
                chk("t5_grant",      64'(grant),        64'(0));
                chk("t5_wr_en",      64'(fifo_wr_en),   64'(0));
                chk("t5_ready",      64'(req_ready),    64'(0));
                chk("t5_wr_data",    64'(fifo_wr_data), 64'(0));
                chk("t5_word_count", 64'(word_count),   64'(0));
            end else begin
                tick();
            end
        end
        chk("t5_hit", 64'(hit), 64'(1));
        tick();
        wr_rst_n = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            settle();
            if (grant != 0) begin
                found = 1'b1;
                chk("t5_first_grant", 64'(grant), 64'(4'b0001));
            end
            tick();
        end
        chk("t5_granted", 64'(found), 64'(1));
        req_valid = '0;

`ifdef FIFO_WR_ARB_ALMOST_FULL_EN
        // 6) almost_full blocks new grants only
        do_reset();
        fifo_almost_full = 1'b1;
        req_valid = 4'hF;
        repeat (3) begin
            settle();
            chk("t6_af_no_grant", 64'(grant), 64'(0));
            tick();
        end
        fifo_almost_full = 1'b0;
        settle();
        chk("t6_af_still_idle", 64'(grant), 64'(0));
        tick();
        settle();
        chk("t6_af_grant", 64'(grant), 64'(4'b0001));
        tick();
        fifo_almost_full = 1'b1;
        post = 1;  // first word was written in the grant cycle checked above
        rel  = 1'b0;
        for (int cyc = 0; cyc < 20 && !rel; cyc++) begin
            settle();
            if (grant == 0) rel = 1'b1;
            else if (fifo_wr_en) post++;
            tick();
        end
        chk("t6_burst_words", 64'(post), 64'(4));
        fifo_almost_full = 1'b0;
        req_valid = '0;
`endif

        // 7) Randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            req_valid        = ~(4'($urandom) & 4'($urandom));
            req_data         = {$urandom, $urandom};
            fifo_full        = ($urandom_range(0, 4) == 0);
            fifo_almost_full = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end

        req_valid = '0;
        fifo_full = 1'b0;
        tick();
        settle();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
